// File: rtl/sdr_fir_pkg.sv
// sdr_fir_pkg: shared polyphase FIR constants, FSM encoding and helpers.
package sdr_fir_pkg;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int L = 4;
    localparam int T = 32;
    localparam int N_TAPS = L * T;
    localparam int N_TRUNC = 15;
    // Flush cycles after the last read so each phase spans T+5 clocks
    localparam int DRAIN_LEN = 4;

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, NEXT} state_t;

    // Interpolation filter taps; every phase sums above unity (2^N_TRUNC)
    function automatic int coef(input int i);
        return 1201 + ((i * 73) % 97) * 23;
    endfunction
endpackage

// File: rtl/ram_2_port_rden.sv
// ram_2_port_rden: simple dual-port RAM with read enable and registered read data.
module ram_2_port_rden
    import sdr_fir_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                      clk,
    input  logic                      wren,
    input  logic [clog2(DEPTH)-1:0]   wraddr,
    input  logic [WIDTH-1:0]          data,
    input  logic                      rden,
    input  logic [clog2(DEPTH)-1:0]   rdaddr,
    output logic [WIDTH-1:0]          q
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wren) mem[wraddr] <= data;
        if (rden) q <= mem[rdaddr];
    end
endmodule

// File: rtl/tx_interp_fir_rom.sv
// tx_interp_fir_rom: coefficient ROM for the interpolator, registered output.
module tx_interp_fir_rom
    import sdr_fir_pkg::*;
#(
    parameter int DEPTH = N_TAPS,
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic [clog2(DEPTH)-1:0]   addr,
    output logic signed [WIDTH-1:0]   q
);
    logic signed [WIDTH-1:0] mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign mem[i] = WIDTH'(coef(i));
    end

    always_ff @(posedge clk) q <= mem[addr];
endmodule

// File: rtl/tx_interp_fir.sv
// tx_interp_fir: two-channel 1:L polyphase interpolating FIR with a shared
// coefficient path, one MAC per channel, round-half-up and saturation.
module tx_interp_fir
    import sdr_fir_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int COEF_SIZE = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        strobe_in,
    input  logic signed [DATA_SIZE-1:0] ch1_in,
    input  logic signed [DATA_SIZE-1:0] ch2_in,
    input  logic                        clr_overrun,
    output logic                        strobe_out,
    output logic signed [DATA_SIZE-1:0] ch1_out,
    output logic signed [DATA_SIZE-1:0] ch2_out,
    output logic                        busy,
    output logic                        overrun
);
    localparam int ACC_SIZE = DATA_SIZE + COEF_SIZE + clog2(T);
    localparam int AW = clog2(T);
    localparam int PW = clog2(L);
    localparam int CW = clog2(N_TAPS);
    localparam int MW = DATA_SIZE + COEF_SIZE;
    localparam int RW = ACC_SIZE - N_TRUNC + 1;

    state_t state, nxt;
    logic [AW-1:0] cnt, wr_addr, rd_addr;
    logic [PW-1:0] phase;
    logic [CW-1:0] rom_addr;
    logic accept, last, rd_v, rd_f, v1, f1, v2, f2, load;
    logic signed [DATA_SIZE-1:0] x1, x2;
    logic signed [COEF_SIZE-1:0] c;
    logic signed [MW-1:0] p1, p2;
    logic signed [ACC_SIZE-1:0] acc1, acc2;

    function automatic logic signed [DATA_SIZE-1:0] round_sat(input logic signed [ACC_SIZE-1:0] a);
        logic signed [RW-1:0] r;
        r = RW'(a >>> N_TRUNC) + RW'(a[N_TRUNC-1]);
        return (r[RW-1:DATA_SIZE-1] == {(RW-DATA_SIZE+1){r[RW-1]}}) ? r[DATA_SIZE-1:0]
             : {r[RW-1], {(DATA_SIZE-1){~r[RW-1]}}};
    endfunction

    // A strobe arriving with the final output pulse starts the next sample
    assign last = phase == PW'(L - 1);
    assign accept = strobe_in && (!busy || (strobe_out && last));
    assign rd_v = state == MAC;
    assign rd_f = rd_v && cnt == '0;
    assign load = state == DRAIN && cnt == AW'(DRAIN_LEN - 1);
    assign rd_addr = wr_addr - AW'(1) - cnt;
    assign rom_addr = CW'(cnt) * CW'(L) + CW'(phase);

    ram_2_port_rden #(.WIDTH(DATA_SIZE), .DEPTH(T)) u_ram1 (
        .clk(clk), .wren(accept), .wraddr(wr_addr), .data(ch1_in),
        .rden(rd_v), .rdaddr(rd_addr), .q(x1)
    );
    ram_2_port_rden #(.WIDTH(DATA_SIZE), .DEPTH(T)) u_ram2 (
        .clk(clk), .wren(accept), .wraddr(wr_addr), .data(ch2_in),
        .rden(rd_v), .rdaddr(rd_addr), .q(x2)
    );
    tx_interp_fir_rom #(.DEPTH(N_TAPS), .WIDTH(COEF_SIZE)) u_rom (
        .clk(clk), .addr(rom_addr), .q(c)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = accept ? MAC : IDLE;
            MAC:   nxt = (cnt == AW'(T - 1)) ? DRAIN : MAC;
            DRAIN: nxt = load ? (last ? IDLE : NEXT) : DRAIN;
            NEXT:  nxt = MAC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            phase <= '0;
            wr_addr <= '0;
        end else begin
            state <= nxt;
            cnt <= (nxt != state) ? '0 : cnt + AW'(1);
            phase <= accept ? '0 : (state == NEXT) ? phase + PW'(1) : phase;
            if (accept) wr_addr <= wr_addr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {v1, f1, v2, f2} <= '0;
            p1 <= '0;
            p2 <= '0;
            acc1 <= '0;
            acc2 <= '0;
        end else begin
            {v1, f1, v2, f2} <= {rd_v, rd_f, v1, f1};
            p1 <= x1 * c;
            p2 <= x2 * c;
            if (v2) begin
                acc1 <= f2 ? ACC_SIZE'(p1) : acc1 + ACC_SIZE'(p1);
                acc2 <= f2 ? ACC_SIZE'(p2) : acc2 + ACC_SIZE'(p2);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_out <= 1'b0;
            ch1_out <= '0;
            ch2_out <= '0;
            busy <= 1'b0;
            overrun <= 1'b0;
        end else begin
            strobe_out <= load;
            if (load) begin
                ch1_out <= round_sat(acc1);
                ch2_out <= round_sat(acc2);
            end
            busy <= accept || (busy && !(strobe_out && last));
            overrun <= (strobe_in && !accept) || (overrun && !clr_overrun);
        end
    end
endmodule

// File: tb/tb_tx_interp_fir.sv
// tb_tx_interp_fir: directed and randomized checks of tx_interp_fir against a
// sample-level model (delay line array + convolution sum per output phase).
module tb_tx_interp_fir;
    typedef struct {int t; int v1; int v2;} ev_t;

    logic clk = 0, reset_n = 0, strobe_in = 0, clr_overrun = 0;
    logic signed [15:0] ch1_in = 0, ch2_in = 0;
    logic strobe_out, busy, overrun;
    logic signed [15:0] ch1_out, ch2_out;

    int cyc = -1, n_chk = 0, n_err = 0;
    ev_t q[$];
    int mem1[32], mem2[32];
    int ptr = 0, acc_t = -1000, acc_prev = -1000;
    bit drv_acc = 0, chk_data = 0, exp_ovr = 0;
    int cur1 = 0, cur2 = 0;
    int rec_t[$], rec1[$], rec2[$];

    tx_interp_fir dut (
        .clk(clk), .reset_n(reset_n), .strobe_in(strobe_in),
        .ch1_in(ch1_in), .ch2_in(ch2_in), .clr_overrun(clr_overrun),
        .strobe_out(strobe_out), .ch1_out(ch1_out), .ch2_out(ch2_out),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int coef(input int i);
        return 1201 + ((i * 73) % 97) * 23;
    endfunction

    // y_p = sum_k x[n-k] * c[4k+p], then round half up by 2^15 and clamp
    function automatic int model_y(input int p, input bit second);
        longint s = 0;
        for (int k = 0; k < 32; k++)
            s += longint'(second ? mem2[(ptr - 1 - k) & 31] : mem1[(ptr - 1 - k) & 31]) * coef(4 * k + p);
        s = (s + 16384) >>> 15;
        return s > 32767 ? 32767 : s < -32768 ? -32768 : int'(s);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d, required %0d", name, cyc + 1, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int t;
        bit es;
        t = cyc + 1;
        if (!reset_n) begin
            chk("reset strobe_out", strobe_out, 0);
            chk("reset busy", busy, 0);
            chk("reset overrun", overrun, 0);
            chk("reset ch1_out", ch1_out, 0);
            chk("reset ch2_out", ch2_out, 0);
            exp_ovr = 0;
            cur1 = 0;
            cur2 = 0;
        end else if (cyc >= 0) begin
            es = q.size() > 0 && q[0].t == t;
            chk("strobe_out", strobe_out, es);
            if (es) begin
                cur1 = q[0].v1;
                cur2 = q[0].v2;
                void'(q.pop_front());
            end
            chk("busy", busy, (t > acc_t && t <= acc_t + 148) || (t > acc_prev && t <= acc_prev + 148));
            chk("overrun", overrun, exp_ovr);
            if (chk_data) begin
                chk("ch1_out", ch1_out, cur1);
                chk("ch2_out", ch2_out, cur2);
            end
            if (strobe_out) begin
                rec_t.push_back(t);
                rec1.push_back(ch1_out);
                rec2.push_back(ch2_out);
            end
            exp_ovr = (strobe_in && !drv_acc) || (exp_ovr && !clr_overrun);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int t);
        while (cyc + 1 < t) tick();
    endtask

    task automatic send(input int d1, input int d2);
        int t = cyc + 1;
        ev_t e;
        strobe_in = 1;
        ch1_in = 16'(d1);
        ch2_in = 16'(d2);
        drv_acc = t >= acc_t + 148;
        if (drv_acc) begin
            mem1[ptr] = d1;
            mem2[ptr] = d2;
            ptr = (ptr + 1) % 32;
            for (int p = 0; p < 4; p++) begin
                e.t = t + 37 * (p + 1);
                e.v1 = model_y(p, 0);
                e.v2 = model_y(p, 1);
                q.push_back(e);
            end
            acc_prev = acc_t;
            acc_t = t;
        end
        tick();
        strobe_in = 0;
        drv_acc = 0;
    endtask

    task automatic do_reset(input int n);
        reset_n = 0;
        q.delete();
        ptr = 0;
        acc_t = -1000;
        acc_prev = -1000;
        repeat (n) tick();
        reset_n = 1;
    endtask

    function automatic int rnd();
        return $urandom_range(0, 1) ? int'($urandom_range(0, 65535)) - 32768
                                    : int'($urandom_range(0, 8000)) - 4000;
    endfunction

    initial begin
        int t0;
        do_reset(3);
        for (int i = 0; i < 32; i++) begin
            go(acc_t + 148);
            send(0, 0);
        end
        go(acc_t + 150);
        chk_data = 1;

        // impulse response and phase timing
        rec_t.delete(); rec1.delete(); rec2.delete();
        t0 = cyc + 1;
        send(16384, 0);
        for (int i = 1; i < 32; i++) begin
            go(t0 + 200 * i);
            send(0, 0);
        end
        go(acc_t + 150);
        chk("impulse count", rec1.size(), 128);
        if (rec1.size() >= 128) begin
            for (int p = 0; p < 4; p++) chk("phase timing", rec_t[p], t0 + 37 * (p + 1));
            chk("impulse c0", rec1[0], 601);
            chk("impulse c1", rec1[1], 1440);
            chk("impulse c2", rec1[2], 1164);
            chk("impulse c3", rec1[3], 888);
            for (int i = 0; i < 128; i++) begin
                chk("impulse ch1", rec1[i], (coef(i) + 1) / 2);
                chk("impulse ch2", rec2[i], 0);
            end
        end

        // saturation with back-to-back strobes on the final output pulse
        rec_t.delete(); rec1.delete(); rec2.delete();
        for (int i = 0; i < 32; i++) begin
            go(acc_t + 148);
            send(32767, -32768);
        end
        go(acc_t + 150);
        chk("boundary count", rec1.size(), 128);
        chk("boundary overrun", overrun, 0);
        if (rec1.size() > 0) begin
            chk("sat pos", rec1[rec1.size() - 1], 32767);
            chk("sat neg", rec2[rec2.size() - 1], -32768);
            chk("boundary timing", rec_t[rec_t.size() - 1], acc_t + 148);
        end

        // overrun: dropped strobe, clear, and set winning over clear
        t0 = cyc + 1;
        send(rnd(), rnd());
        go(t0 + 100);
        send(12345, -2345);
        chk("overrun set", overrun, 1);
        go(t0 + 148);
        send(rnd(), rnd());
        clr_overrun = 1;
        tick();
        clr_overrun = 0;
        chk("overrun clear", overrun, 0);
        go(acc_t + 60);
        clr_overrun = 1;
        send(777, 777);
        clr_overrun = 0;
        chk("overrun set wins", overrun, 1);

        // reset mid-computation, then a normal run
        go(acc_t + 148);
        t0 = cyc + 1;
        send(rnd(), rnd());
        go(t0 + 50);
        do_reset(2);
        repeat (200) tick();
        send(rnd(), rnd());
        go(acc_t + 150);

        for (int i = 0; i < 24; i++) begin
            go(acc_t + 148 + int'($urandom_range(0, 20)));
            send(rnd(), rnd());
            if ($urandom_range(0, 2) == 0) begin
                go(acc_t + int'($urandom_range(2, 140)));
                clr_overrun = 1'($urandom_range(0, 1));
                send(rnd(), rnd());
                clr_overrun = 0;
            end
            if ($urandom_range(0, 3) == 0) begin
                clr_overrun = 1;
                tick();
                clr_overrun = 0;
            end
        end
        go(acc_t + 160);
        chk("outputs drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
